// File: rtl/tableau_row_streamer.sv
// Stabilizer tableau store that scans its rows and streams those whose literal in a chosen
// column overlaps a literal mask, under a valid/ready handshake; rows are rewritable between scans.
module tableau_row_streamer #(
    parameter int num_qubit = 4,
    parameter int addr_w    = 2
) (
    input  logic                     clk,
    input  logic                     rst_new,
    input  logic                     wr_en,
    input  logic [addr_w-1:0]        wr_addr,
    input  logic [2*num_qubit-1:0]   wr_literals,
    input  logic                     wr_phase,
    input  logic                     start,
    input  logic [addr_w-1:0]        col,
    input  logic [1:0]               match_sel,
    output logic [2*num_qubit-1:0]   literals_out,
    output logic                     phase_out,
    output logic [addr_w-1:0]        row_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [addr_w:0]          match_count
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [addr_w-1:0]        ptr_q, ptr_d;
    logic [addr_w-1:0]        col_q, col_d;
    logic [1:0]               sel_q, sel_d;
    logic [2*num_qubit-1:0]   lit_out_q, lit_out_d;
    logic                     phase_out_q, phase_out_d;
    logic [addr_w-1:0]        row_idx_q, row_idx_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [addr_w:0]          count_q, count_d;

    logic [2*num_qubit-1:0]   lit_q [num_qubit];
    logic [num_qubit-1:0]     ph_q;
    logic                     wr_ok;
    logic [2*num_qubit-1:0]   row_lit;
    logic [1:0]               col_lit;
    logic                     hit;
    logic                     last_row;

    // Writes are only honoured while no scan is reading the tableau.
    assign wr_ok = wr_en && (state_q == IDLE || state_q == DONE) && (32'(wr_addr) < num_qubit);

    generate
        for (genvar gi = 0; gi < num_qubit; gi++) begin : g_row
            localparam logic [2*num_qubit-1:0] row_rst = {{(2*num_qubit-1){1'b0}}, 1'b1} << (2*gi);
            always_ff @(posedge clk or posedge rst_new) begin
                if (rst_new) begin
                    lit_q[gi] <= row_rst;
                    ph_q[gi]  <= 1'b0;
                end else if (wr_ok && wr_addr == addr_w'(gi)) begin
                    lit_q[gi] <= wr_literals;
                    ph_q[gi]  <= wr_phase;
                end
            end
        end
    endgenerate

    // Columns beyond the last qubit select nothing, so they never match.
    always_comb begin
        row_lit = lit_q[ptr_q];
        col_lit = 2'b00;
        for (int q = 0; q < num_qubit; q++) begin
            if (col_q == addr_w'(q)) col_lit = row_lit[2*q +: 2];
        end
    end

    assign hit      = |(col_lit & sel_q);
    assign last_row = (ptr_q == addr_w'(num_qubit - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        col_d       = col_q;
        sel_d       = sel_q;
        lit_out_d   = lit_out_q;
        phase_out_d = phase_out_q;
        row_idx_d   = row_idx_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    col_d   = col;
                    sel_d   = match_sel;
                    ptr_d   = '0;
                    count_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    lit_out_d   = row_lit;
                    phase_out_d = ph_q[ptr_q];
                    row_idx_d   = ptr_q;
                    out_valid_d = 1'b1;
                    state_d     = EMIT;
                end else if (last_row) begin
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = count_q + 1'b1;
                    if (last_row) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            col_q       <= '0;
            sel_q       <= '0;
            lit_out_q   <= '0;
            phase_out_q <= 1'b0;
            row_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            col_q       <= col_d;
            sel_q       <= sel_d;
            lit_out_q   <= lit_out_d;
            phase_out_q <= phase_out_d;
            row_idx_q   <= row_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign literals_out = lit_out_q;
    assign phase_out    = phase_out_q;
    assign row_idx      = row_idx_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign match_count  = count_q;

endmodule

// File: tb/tb_tableau_row_streamer.sv
// Directed bench for tableau_row_streamer: row literals are packed with qubit i in bits [2i+1:2i],
// so the row {X,Y,I,Z} listed from qubit 0 upward is 8'b01_00_11_10.
module tb_tableau_row_streamer;

    logic       clk = 1'b0;
    logic       rst_new;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_literals;
    logic       wr_phase;
    logic       start;
    logic [1:0] col;
    logic [1:0] match_sel;
    logic [7:0] literals_out;
    logic       phase_out;
    logic [1:0] row_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [2:0] match_count;

    int checks   = 0;
    int failures = 0;

    int         n_emit;
    logic [1:0] em_idx [4];
    logic [7:0] em_lit [4];
    logic       em_ph  [4];

    tableau_row_streamer #(.num_qubit(4), .addr_w(2)) dut (
        .clk         (clk),
        .rst_new     (rst_new),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_literals (wr_literals),
        .wr_phase    (wr_phase),
        .start       (start),
        .col         (col),
        .match_sel   (match_sel),
        .literals_out(literals_out),
        .phase_out   (phase_out),
        .row_idx     (row_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_row(input logic [1:0] a, input logic [7:0] l, input logic p);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_literals = l; wr_phase = p;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 20);
        check_val(tag, out_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val(tag, done, 1);
        @(negedge clk);
    endtask

    // Start a scan with the consumer always ready and record every emitted row.
    task automatic run_scan(input logic [1:0] c, input logic [1:0] s);
        int cyc = 0;
        logic got_done = 1'b0;
        n_emit = 0;
        @(negedge clk);
        col = c; match_sel = s; start = 1'b1; out_ready = 1'b1;
        while (!got_done && cyc < 30) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (out_valid && n_emit < 4) begin
                em_idx[n_emit] = row_idx;
                em_lit[n_emit] = literals_out;
                em_ph[n_emit]  = phase_out;
                $display("scan col=%0d sel=%b emit row=%0d lit=%b ph=%0d", c, s, row_idx, literals_out, phase_out);
                n_emit++;
            end
            if (done) got_done = 1'b1;
        end
        check_val("scan_done_seen", got_done, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_new = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_literals = '0; wr_phase = 1'b0;
        start = 1'b0; col = '0; match_sel = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_new = 1'b0;
        @(negedge clk);
        check_val("rst_lit",   literals_out, 0);
        check_val("rst_phase", phase_out, 0);
        check_val("rst_idx",   row_idx, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_busy",  busy, 0);
        check_val("rst_done",  done, 0);
        check_val("rst_count", match_count, 0);

        // 1: reset tableau, Z on column 2 only in row 2
        run_scan(2'd2, 2'b01);
        check_val("t1_n",     n_emit, 1);
        check_val("t1_idx",   em_idx[0], 2);
        check_val("t1_lit",   em_lit[0], 8'h10);
        check_val("t1_count", match_count, 1);

        // 2: row1 = {X,Y,I,Z} negative phase, X/Y on column 0
        wr_row(2'd1, 8'h4E, 1'b1);
        run_scan(2'd0, 2'b10);
        check_val("t2_n",     n_emit, 1);
        check_val("t2_idx",   em_idx[0], 1);
        check_val("t2_lit",   em_lit[0], 8'h4E);
        check_val("t2_phase", em_ph[0], 1);
        check_val("t2_count", match_count, 1);

        // 3: rows 0 and 3 carry Z on column 3; stall row 0 for 5 cycles
        wr_row(2'd0, 8'h41, 1'b0);
        wr_row(2'd1, 8'h04, 1'b0);
        @(negedge clk);
        col = 2'd3; match_sel = 2'b01; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_val("t3_lat1_valid", out_valid, 0);
        check_val("t3_lat1_busy",  busy, 1);
        @(negedge clk);
        check_val("t3_lat2_valid", out_valid, 1);
        check_val("t3_row0", {row_idx, phase_out, literals_out}, {2'd0, 1'b0, 8'h41});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("t3_stall", {out_valid, row_idx, phase_out, literals_out}, {1'b1, 2'd0, 1'b0, 8'h41});
        end
        out_ready = 1'b1;
        wait_valid("t3_row3_valid");
        check_val("t3_row3", {row_idx, phase_out, literals_out}, {2'd3, 1'b0, 8'h40});
        wait_done("t3_done");
        check_val("t3_count", match_count, 2);

        // 4: empty mask never matches; done exactly 5 cycles after start
        begin
            logic seen_v = 1'b0;
            @(negedge clk);
            col = 2'd3; match_sel = 2'b00; start = 1'b1; out_ready = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                start = 1'b0;
                check_val($sformatf("t4_done_c%0d", k), done, (k == 5) ? 1 : 0);
                seen_v |= out_valid;
            end
            check_val("t4_no_valid", seen_v, 0);
            check_val("t4_count", match_count, 0);
            check_val("t4_idle", busy, 0);
        end

        // 5: write and start during EMIT are ignored
        @(negedge clk);
        col = 2'd3; match_sel = 2'b01; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_valid("t5_row0_valid");
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd2; wr_literals = 8'h02; wr_phase = 1'b1;
        start = 1'b1; col = 2'd0; match_sel = 2'b10;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        check_val("t5_stall", {out_valid, row_idx, literals_out}, {1'b1, 2'd0, 8'h41});
        out_ready = 1'b1;
        wait_valid("t5_row3_valid");
        check_val("t5_row3_idx", row_idx, 3);
        wait_done("t5_done");
        check_val("t5_count", match_count, 2);
        run_scan(2'd0, 2'b10);
        check_val("t5_reread_n", n_emit, 0);
        run_scan(2'd2, 2'b01);
        check_val("t5_row2_n", n_emit, 1);
        check_val("t5_row2", {em_idx[0], em_ph[0], em_lit[0]}, {2'd2, 1'b0, 8'h10});

        // 6: asynchronous reset while emitting
        @(negedge clk);
        col = 2'd3; match_sel = 2'b01; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_valid("t6_row0_valid");
        rst_new = 1'b1;
        #1;
        check_val("t6_valid", out_valid, 0);
        check_val("t6_busy",  busy, 0);
        check_val("t6_lit",   literals_out, 0);
        check_val("t6_count", match_count, 0);
        @(negedge clk);
        rst_new = 1'b0;
        run_scan(2'd0, 2'b01);
        check_val("t6_row0_n", n_emit, 1);
        check_val("t6_row0", {em_idx[0], em_lit[0]}, {2'd0, 8'h01});
        run_scan(2'd3, 2'b01);
        check_val("t6_row3_n", n_emit, 1);
        check_val("t6_row3", {em_idx[0], em_lit[0]}, {2'd3, 8'h40});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
